// File: rtl/gpredict_arbiter.sv
// -----------------------------------------------------------------------------
// gpredict_arbiter
//
// Purpose:
//   Lets two branch-resolution requesters share one global branch predictor
//   (gpredict). Requests are granted round-robin. The arbiter issues the
//   predictor's one-cycle predict/update strobe and captures the prediction.
//   It then returns that prediction with a mispredict flag, tagged with the
//   requester id. The predictor instance itself is left unmodified.
//
//   Timing, counted from the accept cycle (cycle 0, state IDLE):
//     cycle 0  IDLE     reqN_ready high combinationally, request latched
//     cycle 1  ISSUE    gp_predict_enable high, gp_branch_pc/outcome valid
//     cycle 2  CAPTURE  gp_prediction sampled
//     cycle 3  IDLE     resp_* presented for one cycle; a new request may be
//                       accepted in this same cycle
//
// Parameters:
//   PC_W   branch PC width, must match the predictor's branch_pc width
//   CNT_W  statistics counter width (exists only when GPA_STATS_EN is defined)
//
// Optional feature (compile-time macro GPA_STATS_EN):
//   Adds per-requester branch and mispredict counters. The counters saturate
//   at all-ones. stat_clear zeroes them synchronously and wins over a
//   simultaneous increment. When the macro is undefined, neither the counters
//   nor their ports exist.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req0_valid/ready/pc/outcome   requester 0 handshake and branch info
//   req1_valid/ready/pc/outcome   requester 1 handshake and branch info
//   resp_valid                 one-cycle response strobe
//   resp_id                    requester the response belongs to
//   resp_prediction            predictor output for that branch
//   resp_mispredict            prediction differs from the latched outcome
//   gp_predict_enable          to predictor predict_enable
//   gp_branch_pc               to predictor branch_pc
//   gp_actual_outcome          to predictor actual_outcome
//   gp_prediction              from predictor prediction
//   stat_clear                 (GPA_STATS_EN) synchronous counter clear
//   stat0/1_branches/_mispred  (GPA_STATS_EN) per-requester counters
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module gpredict_arbiter #(
  parameter int PC_W = 8
`ifdef GPA_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [PC_W-1:0] req0_pc,
  input  logic            req0_outcome,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [PC_W-1:0] req1_pc,
  input  logic            req1_outcome,

  output logic            resp_valid,
  output logic            resp_id,
  output logic            resp_prediction,
  output logic            resp_mispredict,

  output logic            gp_predict_enable,
  output logic [PC_W-1:0] gp_branch_pc,
  output logic            gp_actual_outcome,
  input  logic            gp_prediction,

`ifdef GPA_STATS_EN
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat0_branches,
  output logic [CNT_W-1:0] stat0_mispred,
  output logic [CNT_W-1:0] stat1_branches,
  output logic [CNT_W-1:0] stat1_mispred,
`endif

  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic [PC_W-1:0] hold_pc;
  logic            hold_outcome;
  logic            hold_id;

  logic            grant0;
  logic            grant1;

  // Round-robin grant, evaluated only in IDLE. Under contention, the
  // requester that was not granted last wins. A lone requester always wins,
  // so it can be served back-to-back. Because last_grant resets to 1,
  // requester 0 wins the first contention after reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // The ready signals are combinational, so each handshake completes in the
  // same cycle the grant is made.
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign busy = (state != IDLE);

  // Main FSM, with all datapath and response outputs registered.
  // The predictor-facing pc/outcome are loaded on accept, together with the
  // holding registers. They are therefore stable throughout ISSUE and keep
  // their last value afterwards. The enable is raised on the accept edge and
  // dropped on the next edge, so it is high only during ISSUE. resp_valid is
  // raised on the CAPTURE edge and cleared by default one cycle later.
  // An asynchronous reset discards any in-flight request, and no response
  // is produced for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      hold_pc           <= '0;
      hold_outcome      <= 1'b0;
      hold_id           <= 1'b0;
      gp_predict_enable <= 1'b0;
      gp_branch_pc      <= '0;
      gp_actual_outcome <= 1'b0;
      resp_valid        <= 1'b0;
      resp_id           <= 1'b0;
      resp_prediction   <= 1'b0;
      resp_mispredict   <= 1'b0;
    end else begin
      gp_predict_enable <= 1'b0;
      resp_valid        <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            hold_pc           <= grant1 ? req1_pc : req0_pc;
            hold_outcome      <= grant1 ? req1_outcome : req0_outcome;
            hold_id           <= grant1;
            last_grant        <= grant1;
            gp_branch_pc      <= grant1 ? req1_pc : req0_pc;
            gp_actual_outcome <= grant1 ? req1_outcome : req0_outcome;
            gp_predict_enable <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          resp_valid      <= 1'b1;
          resp_id         <= hold_id;
          resp_prediction <= gp_prediction;
          resp_mispredict <= (gp_prediction != hold_outcome);
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GPA_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic inc0_branch;
  logic inc0_mispred;
  logic inc1_branch;
  logic inc1_mispred;

  // The counters observe the registered response strobe. They therefore
  // update on the edge that ends the resp_valid cycle.
  always_comb begin
    inc0_branch  = resp_valid && !resp_id;
    inc1_branch  = resp_valid &&  resp_id;
    inc0_mispred = inc0_branch && resp_mispredict;
    inc1_mispred = inc1_branch && resp_mispredict;
  end

  // The statistics counters saturate at all-ones rather than wrapping.
  // stat_clear is checked first, so a clear takes priority over an
  // increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat0_branches <= '0;
      stat0_mispred  <= '0;
      stat1_branches <= '0;
      stat1_mispred  <= '0;
    end else if (stat_clear) begin
      stat0_branches <= '0;
      stat0_mispred  <= '0;
      stat1_branches <= '0;
      stat1_mispred  <= '0;
    end else begin
      if (inc0_branch && (stat0_branches != CNT_MAX))
        stat0_branches <= stat0_branches + 1'b1;
      if (inc0_mispred && (stat0_mispred != CNT_MAX))
        stat0_mispred <= stat0_mispred + 1'b1;
      if (inc1_branch && (stat1_branches != CNT_MAX))
        stat1_branches <= stat1_branches + 1'b1;
      if (inc1_mispred && (stat1_mispred != CNT_MAX))
        stat1_mispred <= stat1_mispred + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gpredict_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpredict_arbiter
//
// Directed testbench for gpredict_arbiter. A small bimodal predictor stands in
// for the gpredict instance. It holds a 2-bit counter per PC, starting at
// weakly-not-taken. The counter's MSB is registered as the prediction on the
// enable edge, and the counter is then trained with the outcome.
// Expected predictions are worked out by hand from that table.
// -----------------------------------------------------------------------------
module tb_gpredict_arbiter;

  localparam int PC_W = 8;

  logic            clk;
  logic            reset;
  logic            gp_rst;
  logic            req0_valid, req0_ready, req0_outcome;
  logic [PC_W-1:0] req0_pc;
  logic            req1_valid, req1_ready, req1_outcome;
  logic [PC_W-1:0] req1_pc;
  logic            resp_valid, resp_id, resp_prediction, resp_mispredict;
  logic            gp_predict_enable, gp_actual_outcome, gp_prediction;
  logic [PC_W-1:0] gp_branch_pc;
  logic            busy;
`ifdef GPA_STATS_EN
  logic            stat_clear;
  logic [15:0]     stat0_branches, stat0_mispred, stat1_branches, stat1_mispred;
`endif

  int vectors;
  int miscompares;
  int misCount;

  gpredict_arbiter #(.PC_W(PC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_pc           (req0_pc),
    .req0_outcome      (req0_outcome),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_pc           (req1_pc),
    .req1_outcome      (req1_outcome),
    .resp_valid        (resp_valid),
    .resp_id           (resp_id),
    .resp_prediction   (resp_prediction),
    .resp_mispredict   (resp_mispredict),
    .gp_predict_enable (gp_predict_enable),
    .gp_branch_pc      (gp_branch_pc),
    .gp_actual_outcome (gp_actual_outcome),
    .gp_prediction     (gp_prediction),
`ifdef GPA_STATS_EN
    .stat_clear        (stat_clear),
    .stat0_branches    (stat0_branches),
    .stat0_mispred     (stat0_mispred),
    .stat1_branches    (stat1_branches),
    .stat1_mispred     (stat1_mispred),
`endif
    .busy              (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in global predictor, with its own reset independent of the arbiter.
  logic [1:0] ctrTable [256];
  always_ff @(posedge clk) begin
    if (gp_rst) begin
      for (int i = 0; i < 256; i++) ctrTable[i] <= 2'b01;
      gp_prediction <= 1'b0;
    end else if (gp_predict_enable) begin
      gp_prediction <= ctrTable[gp_branch_pc][1];
      if (gp_actual_outcome && ctrTable[gp_branch_pc] != 2'b11)
        ctrTable[gp_branch_pc] <= ctrTable[gp_branch_pc] + 2'b01;
      else if (!gp_actual_outcome && ctrTable[gp_branch_pc] != 2'b00)
        ctrTable[gp_branch_pc] <= ctrTable[gp_branch_pc] - 2'b01;
    end
  end

  // Every comparison goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives both requester interfaces.
  task automatic applyStimulus(input logic v0, input logic [PC_W-1:0] pc0, input logic o0,
                               input logic v1, input logic [PC_W-1:0] pc1, input logic o1);
    req0_valid   = v0;
    req0_pc      = pc0;
    req0_outcome = o0;
    req1_valid   = v1;
    req1_pc      = pc1;
    req1_outcome = o1;
  endtask

  // Runs one lone request from accept through to its response.
  // Returns at the falling edge of the response cycle (cycle 3).
  task automatic runSingle(input logic id, input logic [PC_W-1:0] pc, input logic outc,
                           input logic expPred, input string tag);
    @(negedge clk);
    applyStimulus(!id, pc, outc, id, pc, outc);
    #1;
    checkOutput({tag, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_gp_en"}, {31'd0, gp_predict_enable}, 32'd1);
    checkOutput({tag, "_gp_pc"}, {24'd0, gp_branch_pc}, {24'd0, pc});
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_resp_early"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({tag, "_resp_id"}, {31'd0, resp_id}, {31'd0, id});
    checkOutput({tag, "_resp_pred"}, {31'd0, resp_prediction}, {31'd0, expPred});
    checkOutput({tag, "_resp_mis"}, {31'd0, resp_mispredict}, {31'd0, expPred != outc});
  endtask

  // Hand-computed predictions for the contention sequence.
  // Requester 0 uses pc 20 with outcome 0, so it is always predicted 0.
  // Requester 1 uses pc 30 with outcome 1, so it is predicted 0, then 1, then 1.
  logic expPredRr [6];
  logic expOutRr  [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    misCount    = 0;
    expPredRr   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    expOutRr    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
`ifdef GPA_STATS_EN
    stat_clear = 1'b0;
`endif

    // Reset held for 3 cycles with no requests.
    reset  = 1'b1;
    gp_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_gp_en", {31'd0, gp_predict_enable}, 32'd0);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    checkOutput("rst_gp_pc", {24'd0, gp_branch_pc}, 32'd0);
    checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
    reset  = 1'b0;
    gp_rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Both requesters valid continuously: grants should alternate 0,1,0,1,0,1,
    // with each response arriving 3 cycles after its accept.
    @(negedge clk);
    applyStimulus(1'b1, 8'd20, 1'b0, 1'b1, 8'd30, 1'b1);
    for (int g = 0; g < 6; g++) begin
      #1;
      checkOutput("rr_ready0", {31'd0, req0_ready}, {31'd0, (g % 2) == 0});
      checkOutput("rr_ready1", {31'd0, req1_ready}, {31'd0, (g % 2) == 1});
      if (g > 0) begin
        checkOutput("rr_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("rr_resp_id", {31'd0, resp_id}, (g - 1) % 2);
        checkOutput("rr_resp_pred", {31'd0, resp_prediction}, {31'd0, expPredRr[g-1]});
        checkOutput("rr_resp_mis", {31'd0, resp_mispredict},
                    {31'd0, expPredRr[g-1] != expOutRr[g-1]});
      end
      @(negedge clk);
      checkOutput("rr_issue_en", {31'd0, gp_predict_enable}, 32'd1);
      checkOutput("rr_issue_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
      @(negedge clk);
      checkOutput("rr_capture_en", {31'd0, gp_predict_enable}, 32'd0);
      checkOutput("rr_capture_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      if (g == 5) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    end
    #1;
    checkOutput("rr_last_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("rr_last_id", {31'd0, resp_id}, 32'd1);
    checkOutput("rr_last_pred", {31'd0, resp_prediction}, 32'd1);
    @(negedge clk);
    checkOutput("rr_resp_oneshot", {31'd0, resp_valid}, 32'd0);
    checkOutput("rr_idle_busy", {31'd0, busy}, 32'd0);

    // Requester 0 alone, pc 10, outcome 1. A fresh counter predicts 0,
    // so this is a mispredict.
    runSingle(1'b0, 8'd10, 1'b1, 1'b0, "single0");

    // Requester 1 alone, 4 times at pc 5, outcome 1. The predictor trains from
    // not-taken to taken: predictions are 0,1,1,1, giving one mispredict.
    for (int k = 0; k < 4; k++) begin
      runSingle(1'b1, 8'd5, 1'b1, (k == 0) ? 1'b0 : 1'b1, "train1");
      misCount += int'(resp_mispredict);
    end
    checkOutput("train1_miscount", misCount, 32'd1);

    // Reset asserted during ISSUE: the request is dropped and no response
    // appears. Afterwards, requester 0 wins contention again.
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'd7, 1'b1);
    #1;
    checkOutput("abort_ready1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("abort_in_issue", {31'd0, gp_predict_enable}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_gp_en", {31'd0, gp_predict_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b1, 8'd41, 1'b0);
    #1;
    checkOutput("abort_fav_ready0", {31'd0, req0_ready}, 32'd1);
    checkOutput("abort_fav_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("abort_new_pc", {24'd0, gp_branch_pc}, 32'd40);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_new_resp", {31'd0, resp_valid}, 32'd1);
    checkOutput("abort_new_id", {31'd0, resp_id}, 32'd0);
    checkOutput("abort_new_mis", {31'd0, resp_mispredict}, 32'd1);

`ifdef GPA_STATS_EN
    // Clear the counters. Then run 3 requester-0 branches with 2 mispredicts:
    // pc 50 predicts 0 (miss), pc 60 predicts 0 (miss), pc 50 predicts 1 (hit).
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    checkOutput("stat_pre_clear", {16'd0, stat0_branches | stat1_branches}, 32'd0);
    runSingle(1'b0, 8'd50, 1'b1, 1'b0, "stat_a");
    runSingle(1'b0, 8'd60, 1'b1, 1'b0, "stat_b");
    runSingle(1'b0, 8'd50, 1'b1, 1'b1, "stat_c");
    @(negedge clk);
    checkOutput("stat0_branches", {16'd0, stat0_branches}, 32'd3);
    checkOutput("stat0_mispred", {16'd0, stat0_mispred}, 32'd2);
    checkOutput("stat1_branches", {16'd0, stat1_branches}, 32'd0);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    checkOutput("stat0_br_clr", {16'd0, stat0_branches}, 32'd0);
    checkOutput("stat0_mis_clr", {16'd0, stat0_mispred}, 32'd0);
    checkOutput("stat1_br_clr", {16'd0, stat1_branches}, 32'd0);
    checkOutput("stat1_mis_clr", {16'd0, stat1_mispred}, 32'd0);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpredict_arbiter.md
Name: gpredict_arbiter

Overview:
- Shares one global branch predictor (gpredict: predict_enable, branch_pc, actual_outcome in; prediction out) between two branch-resolution requesters, e.g. two threads or fetch streams.
- Arbitrates round-robin, drives the predictor's one-cycle predict/update strobe, and captures the resulting prediction.
- Returns the prediction with a mispredict flag, tagged with the requester id.
- Sits between the requesters and the gpredict instance; the predictor itself is unmodified.

Parameters:
- PC_W, 8, branch PC width; must match the predictor's branch_pc width.
- CNT_W, 16, statistics counter width (used only with GPA_STATS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a resolved branch.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_pc  in  PC_W  requester 0 branch PC.
- req0_outcome  in  1  requester 0 actual outcome (1 = taken).
- req1_valid  in  1  same as req0_valid, for requester 1.
- req1_ready  out  1  same as req0_ready, for requester 1.
- req1_pc  in  PC_W  same as req0_pc, for requester 1.
- req1_outcome  in  1  same as req0_outcome, for requester 1.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  1  requester the response belongs to.
- resp_prediction  out  1  predictor output for that branch.
- resp_mispredict  out  1  resp_prediction != latched outcome.
- gp_predict_enable  out  1  to predictor predict_enable.
- gp_branch_pc  out  PC_W  to predictor branch_pc.
- gp_actual_outcome  out  1  to predictor actual_outcome.
- gp_prediction  in  1  from predictor prediction.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states IDLE, ISSUE, CAPTURE, held in a registered state variable.
- IDLE:
  - If either reqN_valid is high, grant one requester.
  - If both are valid, grant the requester not equal to last_grant.
  - Assert that requester's reqN_ready combinationally in the same cycle; handshake completes when valid && ready.
  - Latch pc, outcome and id into holding registers; update last_grant; next state ISSUE.
  - If neither is valid, stay in IDLE.
- ISSUE:
  - gp_predict_enable = 1 for exactly this cycle.
  - gp_branch_pc and gp_actual_outcome driven from the holding registers.
  - Next state CAPTURE.
- CAPTURE:
  - Sample gp_prediction, which is valid in the cycle after the enable edge.
  - Register resp_valid = 1, resp_id, resp_prediction and resp_mispredict = (gp_prediction != held outcome).
  - Next state IDLE.
- Response outputs appear in the cycle following CAPTURE; resp_valid is high for exactly one cycle per accepted request.
- Latency and throughput:
  - Latency from accept (IDLE) to resp_valid is 3 cycles.
  - Maximum throughput is one branch per 3 cycles.
  - The next request can be accepted in the same cycle resp_valid is high.
- reqN_ready is 0 in ISSUE and CAPTURE. Requesters hold valid, pc and outcome stable until ready.
- No response buffering: the consumer must take resp_* in the cycle it is presented.
- Outside ISSUE, gp_predict_enable = 0, and gp_branch_pc and gp_actual_outcome hold their last values.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins the first contention.
  - Holding registers = 0.
  - All outputs = 0, including req*_ready, which is 0 because there is no valid request.
- Reset mid-operation: the in-flight request is discarded with no response. The predictor's own reset is driven separately.
- Simultaneous valid requests strictly alternate. A lone requester is granted back-to-back.

Optional Feature:
- GPA_STATS_EN defined:
  - Adds outputs stat0_branches, stat0_mispred, stat1_branches, stat1_mispred, each CNT_W wide.
  - Counters increment when resp_valid is high for the matching resp_id; the mispred counters increment only when resp_mispredict is also high.
  - Counters saturate at all-ones and reset to 0.
  - Adds input stat_clear (1 bit): synchronously zeroes all four counters; clear wins over a simultaneous increment.
- GPA_STATS_EN undefined: none of these ports or counters exist.

Test Plan:
- Reset held 3 cycles, no requests -> busy = 0, gp_predict_enable = 0, resp_valid never asserts.
- req0 only, pc = 8'd10, outcome = 1 -> req0_ready in cycle 0; gp_predict_enable = 1 with gp_branch_pc = 10 in cycle 1; resp_valid, resp_id = 0 in cycle 3; resp_mispredict = ~resp_prediction.
- req0 and req1 both valid continuously for 6 grants -> grant order 0,1,0,1,0,1; each response is 3 cycles after its accept.
- req1 issued alone 4 times at pc = 8'd5, outcome = 1 against a real gpredict -> resp_prediction settles to 1 after predictor training; the mispredict count matches the bench's reference model.
- Assert reset while in ISSUE -> no resp_valid; state returns to IDLE; next request starts cleanly with requester 0 favoured.
- GPA_STATS_EN: 3 req0 branches with 2 mispredicts, then stat_clear -> stat0_branches = 3 and stat0_mispred = 2 before the clear, all counters 0 after.
